// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator front-panel controller.
//   NUM_DIGITS         : digits in the BCD entry buffer
//   DEFAULT_LONG_TICKS : S2 hold length (clk_db cycles) that counts as a long press
//   BCD_MAX            : largest digit value accepted by a write
//   s2_state_e         : S2 press classifier states
package calc_pkg;

  localparam int unsigned NUM_DIGITS         = 8;
  localparam int unsigned DEFAULT_LONG_TICKS = 100;
  localparam logic [3:0]  BCD_MAX            = 4'd9;

  typedef enum logic [1:0] {IDLE, PRESS, HELD} s2_state_e;

  // Saturating 8-bit increment; the press counter must never wrap.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/key_ctrl_if.sv
// Front-panel bus between the debouncer/display/arithmetic side and key_ctrl.
//   master : drives the debounced buttons/switches, observes the panel state
//   slave  : key_ctrl side
interface key_ctrl_if;

  logic                               s0_in;
  logic                               s1_in;
  logic                               s2_in;
  logic                               s3_in;
  logic                               s4_in;
  logic [7:0]                         sw_in;
  logic [4*calc_pkg::NUM_DIGITS-1:0]  digits;
  logic [2:0]                         cursor;
  logic                               dp_valid;
  logic [2:0]                         dp_pos;
  logic [3:0]                         op_code;
  logic                               confirm;
  logic                               long_hold;
  logic                               err;

  modport master (
    output s0_in, s1_in, s2_in, s3_in, s4_in, sw_in,
    input  digits, cursor, dp_valid, dp_pos, op_code, confirm, long_hold, err
  );

  modport slave (
    input  s0_in, s1_in, s2_in, s3_in, s4_in, sw_in,
    output digits, cursor, dp_valid, dp_pos, op_code, confirm, long_hold, err
  );

endinterface

// File: rtl/press_timer.sv
// S2 press classifier: distinguishes a short press (decimal point) from a long
// press (confirm) by counting clk_db cycles while s2_in is high.
//   clk_db      : debounce-domain clock
//   rst         : synchronous active-high reset
//   s2_in       : debounced S2 level
//   fire        : combinational, high in the cycle whose edge enters HELD
//   short_press : combinational, high in the cycle whose edge ends a short press
//   confirm     : registered one-cycle pulse on a long press
//   long_hold   : registered, high while in HELD
module press_timer
  import calc_pkg::*;
#(
  parameter int unsigned LONG_TICKS = DEFAULT_LONG_TICKS
) (
  input  logic clk_db,
  input  logic rst,
  input  logic s2_in,
  output logic fire,
  output logic short_press,
  output logic confirm,
  output logic long_hold
);

  // Counter holds 1 after the first high sample, so reaching LONG_TICKS-1 while
  // still high means this is the LONG_TICKS-th high sample.
  localparam logic [7:0] LastCnt = 8'(LONG_TICKS - 1);

  s2_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       confirm_q, long_hold_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fire        = 1'b0;
    short_press = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_in) begin
          state_d = PRESS;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = 8'd0;
        end
      end
      PRESS: begin
        if (s2_in) begin
          cnt_d = sat_inc8(cnt_q);
          if (cnt_q == LastCnt) begin
            state_d = HELD;
            fire    = 1'b1;
          end
        end else begin
          state_d     = IDLE;
          cnt_d       = 8'd0;
          short_press = 1'b1;
        end
      end
      HELD: begin
        if (s2_in) begin
          cnt_d = sat_inc8(cnt_q);
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_db) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      confirm_q   <= 1'b0;
      long_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      confirm_q   <= fire;
      long_hold_q <= (state_d == HELD);
    end
  end

  assign confirm   = confirm_q;
  assign long_hold = long_hold_q;

endmodule

// File: rtl/key_ctrl.sv
// Calculator front-panel controller: 8-digit BCD entry buffer, cursor, decimal
// point and operator latch, driven by debounced buttons and switches.
//   clk_db : debounce-domain clock (100 Hz), the only clock
//   rst    : synchronous active-high reset
//   bus    : key_ctrl_if.slave - button/switch inputs and panel state outputs
// Optional build macro AUTO_ADVANCE_EN: an accepted digit write also moves the
// cursor one place right (wrap 0->7), overriding s0/s3 in that cycle.
module key_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned LONG_TICKS = DEFAULT_LONG_TICKS
) (
  input  logic     clk_db,
  input  logic     rst,
  key_ctrl_if.slave bus
);

  localparam int unsigned DigW = 4 * NUM_DIGITS;

  logic [DigW-1:0] digits_q, digits_d;
  logic [2:0]      cursor_q, cursor_d;
  logic            dp_valid_q, dp_valid_d;
  logic [2:0]      dp_pos_q, dp_pos_d;
  logic [3:0]      op_code_q, op_code_d;
  logic            err_q, err_d;

  logic fire, short_press, confirm, long_hold;
  logic digit_ok;
  logic advance;

  press_timer #(
    .LONG_TICKS (LONG_TICKS)
  ) u_press_timer (
    .clk_db      (clk_db),
    .rst         (rst),
    .s2_in       (bus.s2_in),
    .fire        (fire),
    .short_press (short_press),
    .confirm     (confirm),
    .long_hold   (long_hold)
  );

  assign digit_ok = (bus.sw_in[3:0] <= BCD_MAX);

  always_comb begin
    digits_d   = digits_q;
    cursor_d   = cursor_q;
    dp_valid_d = dp_valid_q;
    dp_pos_d   = dp_pos_q;
    op_code_d  = fire ? bus.sw_in[7:4] : op_code_q;
    err_d      = 1'b0;
    advance    = 1'b0;

    if (bus.s4_in) begin
      // Clear overrides writes, cursor moves and a coincident short press.
      digits_d   = '0;
      cursor_d   = 3'd0;
      dp_valid_d = 1'b0;
      dp_pos_d   = 3'd0;
    end else begin
      if (bus.s1_in) begin
        if (digit_ok) begin
          digits_d[{cursor_q, 2'b00} +: 4] = bus.sw_in[3:0];
`ifdef AUTO_ADVANCE_EN
          advance = 1'b1;
`else
          advance = 1'b0;
`endif
        end else begin
          err_d = 1'b1;
        end
      end

      if (advance) begin
        cursor_d = cursor_q - 3'd1;
      end else if (bus.s0_in && !bus.s3_in) begin
        cursor_d = cursor_q + 3'd1;
      end else if (bus.s3_in && !bus.s0_in) begin
        cursor_d = cursor_q - 3'd1;
      end

      // Short press toggles the point at the current cursor, or moves it here.
      if (short_press) begin
        if (dp_valid_q && (dp_pos_q == cursor_q)) begin
          dp_valid_d = 1'b0;
        end else begin
          dp_valid_d = 1'b1;
          dp_pos_d   = cursor_q;
        end
      end
    end
  end

  always_ff @(posedge clk_db) begin
    if (rst) begin
      digits_q   <= '0;
      cursor_q   <= 3'd0;
      dp_valid_q <= 1'b0;
      dp_pos_q   <= 3'd0;
      op_code_q  <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      digits_q   <= digits_d;
      cursor_q   <= cursor_d;
      dp_valid_q <= dp_valid_d;
      dp_pos_q   <= dp_pos_d;
      op_code_q  <= op_code_d;
      err_q      <= err_d;
    end
  end

  assign bus.digits    = digits_q;
  assign bus.cursor    = cursor_q;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_pos    = dp_pos_q;
  assign bus.op_code   = op_code_q;
  assign bus.confirm   = confirm;
  assign bus.long_hold = long_hold;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Self-checking bench for key_ctrl: directed scenarios plus a randomized run,
// all checked against a behavioural model of the front panel.
module tb_key_ctrl;

  localparam int L = 100;

  logic clk_db = 1'b0;
  logic rst    = 1'b1;

  key_ctrl_if bus ();

  key_ctrl #(
    .LONG_TICKS (L)
  ) dut (
    .clk_db (clk_db),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_db = ~clk_db;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state.
  int m_dig[8];
  int m_cur, m_dpp, m_op, m_h;
  bit m_dpv, m_held, m_conf, m_err;

  function automatic logic [31:0] m_digits();
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*4 +: 4] = 4'(m_dig[i]);
    return v;
  endfunction

  // Drive one cycle of inputs, advance the clock, update the model.
  task automatic cycle(input bit s0, input bit s1, input bit s2, input bit s3, input bit s4,
                       input logic [7:0] sw, input bit r);
    int  old_cur;
    bit  short_p;
    bit  adv;
    bus.s0_in = s0; bus.s1_in = s1; bus.s2_in = s2; bus.s3_in = s3; bus.s4_in = s4;
    bus.sw_in = sw; rst = r;
    @(posedge clk_db);
    if (r) begin
      for (int i = 0; i < 8; i++) m_dig[i] = 0;
      m_cur = 0; m_dpv = 0; m_dpp = 0; m_op = 0; m_h = 0; m_held = 0; m_conf = 0; m_err = 0;
    end else begin
      m_conf  = 0;
      m_err   = 0;
      short_p = 0;
      old_cur = m_cur;
      if (s2) begin
        if (m_h < 255) m_h++;
        if (!m_held && m_h == L) begin
          m_conf = 1; m_held = 1; m_op = int'(sw[7:4]);
        end
      end else begin
        if (m_h > 0 && !m_held) short_p = 1;
        m_h = 0; m_held = 0;
      end
      if (s4) begin
        for (int i = 0; i < 8; i++) m_dig[i] = 0;
        m_cur = 0; m_dpv = 0; m_dpp = 0;
      end else begin
        adv = 0;
        if (s1) begin
          if (int'(sw[3:0]) <= 9) begin
            m_dig[old_cur] = int'(sw[3:0]);
`ifdef AUTO_ADVANCE_EN
            adv = 1;
`endif
          end else begin
            m_err = 1;
          end
        end
        if (adv) m_cur = (old_cur + 7) % 8;
        else if (s0 && !s3) m_cur = (old_cur + 1) % 8;
        else if (s3 && !s0) m_cur = (old_cur + 7) % 8;
        if (short_p) begin
          if (m_dpv && m_dpp == old_cur) m_dpv = 0;
          else begin m_dpv = 1; m_dpp = old_cur; end
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic [7:0] sw);
    cycle(0, 0, 0, 0, 0, sw, 0);
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 0, 8'h00, 1);
    cycle(0, 0, 1, 0, 0, 8'h00, 1);
    n_checks++;
    if (bus.digits !== 32'h0 || bus.cursor !== 3'd0 || bus.dp_valid !== 1'b0 ||
        bus.dp_pos !== 3'd0 || bus.op_code !== 4'd0 || bus.confirm !== 1'b0 ||
        bus.long_hold !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: digits=%h cursor=%0d dpv=%b dpp=%0d op=%h conf=%b lh=%b err=%b, want all 0",
               bus.digits, bus.cursor, bus.dp_valid, bus.dp_pos, bus.op_code, bus.confirm,
               bus.long_hold, bus.err);
    end
    idle(8'h00);
  endtask

  task automatic test_cursor();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if (bus.cursor !== 3'd3) begin
      n_fail++; $display("FAIL cursor_left: got %0d want 3", bus.cursor);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 8'h00, 0);
    n_checks++;
    if (bus.cursor !== 3'd7) begin
      n_fail++; $display("FAIL cursor_right_wrap: got %0d want 7", bus.cursor);
    end
    cycle(1, 0, 0, 1, 0, 8'h00, 0);
    n_checks++;
    if (bus.cursor !== 3'd7) begin
      n_fail++; $display("FAIL cursor_both: got %0d want 7", bus.cursor);
    end
  endtask

  task automatic test_write();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 8'h00, 0);   // 7 -> 2
    cycle(0, 1, 0, 0, 0, 8'h05, 0);
    n_checks++;
    if (bus.digits !== 32'h0000_0500 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ok: digits=%h err=%b want 00000500 err=0", bus.digits, bus.err);
    end
    cycle(0, 1, 0, 0, 0, 8'h0C, 0);
    n_checks++;
    if (bus.digits !== 32'h0000_0500 || bus.err !== 1'b1 || bus.cursor !== 3'(m_cur)) begin
      n_fail++;
      $display("FAIL write_reject: digits=%h err=%b cursor=%0d want 00000500 err=1 cursor=%0d",
               bus.digits, bus.err, bus.cursor, m_cur);
    end
    idle(8'h00);
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++; $display("FAIL err_one_cycle: got %b want 0", bus.err);
    end
  endtask

  task automatic test_dp();
    int conf_seen;
    for (int i = 0; i < 8 && m_cur != 4; i++) cycle(1, 0, 0, 0, 0, 8'h00, 0);
    for (int rep = 0; rep < 2; rep++) begin
      conf_seen = 0;
      for (int i = 0; i < 10; i++) begin
        cycle(0, 0, 1, 0, 0, 8'h00, 0);
        if (bus.confirm === 1'b1) conf_seen++;
      end
      idle(8'h00);
      n_checks++;
      if (bus.dp_valid !== (rep == 0) || (rep == 0 && bus.dp_pos !== 3'd4) || conf_seen != 0) begin
        n_fail++;
        $display("FAIL short_press_%0d: dpv=%b dpp=%0d confirms=%0d want dpv=%b dpp=4 confirms=0",
                 rep, bus.dp_valid, bus.dp_pos, conf_seen, rep == 0);
      end
    end
  endtask

  task automatic test_long();
    int conf_cnt, conf_at, lh_bad;
    bit dpv0;
    dpv0 = m_dpv;
    conf_cnt = 0; conf_at = -1; lh_bad = 0;
    for (int i = 0; i < 150; i++) begin
      cycle(0, 0, 1, 0, 0, 8'hA0, 0);
      if (bus.confirm === 1'b1) begin conf_cnt++; conf_at = i; end
      if (bus.long_hold !== (i >= L - 1)) lh_bad++;
    end
    n_checks++;
    if (conf_cnt != 1 || conf_at != L - 1) begin
      n_fail++;
      $display("FAIL confirm_timing: count=%0d at=%0d want count=1 at=%0d", conf_cnt, conf_at, L - 1);
    end
    n_checks++;
    if (bus.op_code !== 4'hA || lh_bad != 0) begin
      n_fail++;
      $display("FAIL long_hold: op=%h bad_cycles=%0d want op=a bad_cycles=0", bus.op_code, lh_bad);
    end
    idle(8'h00);
    n_checks++;
    if (bus.long_hold !== 1'b0 || bus.dp_valid !== dpv0) begin
      n_fail++;
      $display("FAIL long_release: lh=%b dpv=%b want lh=0 dpv=%b", bus.long_hold, bus.dp_valid, dpv0);
    end
  endtask

  task automatic test_clear();
    cycle(1, 0, 0, 0, 0, 8'h00, 0);
    cycle(0, 1, 0, 0, 0, 8'h03, 0);
    cycle(0, 1, 0, 0, 1, 8'h08, 0);
    n_checks++;
    if (bus.digits !== 32'h0 || bus.cursor !== 3'd0 || bus.dp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_prio: digits=%h cursor=%0d dpv=%b want 0 0 0",
               bus.digits, bus.cursor, bus.dp_valid);
    end
  endtask

  task automatic test_rst_mid_press();
    int conf_seen;
    conf_seen = 0;
    for (int i = 0; i < 50; i++) cycle(0, 0, 1, 0, 0, 8'h50, 0);
    cycle(0, 0, 1, 0, 0, 8'h50, 1);
    for (int i = 0; i < 60; i++) begin
      cycle(0, 0, 1, 0, 0, 8'h50, 0);
      if (bus.confirm === 1'b1 || bus.long_hold === 1'b1) conf_seen++;
    end
    n_checks++;
    if (conf_seen != 0 || bus.op_code !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_mid_press: confirm_cycles=%0d op=%h want 0 0", conf_seen, bus.op_code);
    end
    idle(8'h00);
    n_checks++;
    if (bus.dp_valid !== 1'b1 || bus.dp_pos !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_new_press: dpv=%b dpp=%0d want 1 0", bus.dp_valid, bus.dp_pos);
    end
  endtask

`ifdef AUTO_ADVANCE_EN
  task automatic test_auto_advance();
    cycle(0, 0, 0, 0, 1, 8'h00, 0);
    cycle(0, 1, 0, 0, 0, 8'h07, 0);
    n_checks++;
    if (bus.digits[3:0] !== 4'd7 || bus.cursor !== 3'd7) begin
      n_fail++;
      $display("FAIL auto_advance: nib0=%h cursor=%0d want 7 7", bus.digits[3:0], bus.cursor);
    end
  endtask
`endif

  task automatic test_random();
    int s2_left;
    bit s2;
    s2_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (s2_left > 0) begin
        s2 = 1; s2_left--;
      end else begin
        s2 = 0;
        if ($urandom_range(0, 15) == 0) s2_left = int'($urandom_range(1, 130));
      end
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, s2,
            $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0,
            8'($urandom_range(0, 255)), $urandom_range(0, 700) == 0);
      n_checks++;
      if (bus.digits !== m_digits() || bus.cursor !== 3'(m_cur) || bus.dp_valid !== m_dpv ||
          (m_dpv && bus.dp_pos !== 3'(m_dpp)) || bus.op_code !== 4'(m_op) ||
          bus.confirm !== m_conf || bus.long_hold !== m_held || bus.err !== m_err) begin
        n_fail++;
        $display("FAIL random cyc %0d: got d=%h c=%0d dv=%b dp=%0d op=%h cf=%b lh=%b e=%b want d=%h c=%0d dv=%b dp=%0d op=%h cf=%b lh=%b e=%b",
                 i, bus.digits, bus.cursor, bus.dp_valid, bus.dp_pos, bus.op_code, bus.confirm,
                 bus.long_hold, bus.err, m_digits(), m_cur, m_dpv, m_dpp, m_op, m_conf, m_held,
                 m_err);
      end
    end
  endtask

  initial begin
    bus.s0_in = 0; bus.s1_in = 0; bus.s2_in = 0; bus.s3_in = 0; bus.s4_in = 0;
    bus.sw_in = 8'h00;
    test_reset();
    test_cursor();
    test_write();
    test_dp();
    test_long();
    test_clear();
    test_rst_mid_press();
`ifdef AUTO_ADVANCE_EN
    test_auto_advance();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_ctrl.md
# key_ctrl

Calculator front-panel controller directly downstream of the button/switch debouncer, running in the same 100 Hz debounce clock domain. It consumes the debounced one-cycle pulses (S0, S1, S3, S4), the S2 level and the 8 switch levels. From these it maintains an 8-digit BCD entry buffer, a cursor and a decimal-point position, and it classifies S2 presses as short (decimal point) or long (confirm). Its outputs feed the display driver and the arithmetic core.

## Interface
- LONG_TICKS, 100: S2 hold length in clk_db cycles (1 s at 100 Hz) that counts as a long press; legal range 2..255.
- clk_db  in  1  debounce-domain clock (100 Hz); the only clock.
- rst  in  1  **reset is synchronous and active-high**.
- s0_in  in  1  debounced pulse: move cursor left.
- s1_in  in  1  debounced pulse: write digit.
- s2_in  in  1  debounced level: decimal point (short press) / confirm (long press).
- s3_in  in  1  debounced pulse: move cursor right.
- s4_in  in  1  debounced pulse: clear entry.
- sw_in  in  8  debounced switches: [3:0] digit value, [7:4] operator code.
- digits  out  32  entry buffer, 8 BCD nibbles; nibble 0 is rightmost.
- cursor  out  3  selected digit index.
- dp_valid  out  1  decimal point present.
- dp_pos  out  3  digit index carrying the decimal point.
- op_code  out  4  sw_in[7:4] latched at confirm.
- confirm  out  1  one-cycle pulse on a long press.
- long_hold  out  1  high from confirm until S2 is released.
- err  out  1  one-cycle pulse on a rejected digit (value > 9).

## Operation
- Reset values: digits=0, cursor=0, dp_valid=0, dp_pos=0, op_code=0, confirm=0, long_hold=0, err=0; S2 FSM in IDLE with the press counter at 0.
- Cursor movement:
  - s0_in increments cursor with wrap 7→0.
  - s3_in decrements cursor with wrap 0→7.
  - s0_in and s3_in in the same cycle: cursor unchanged.
- Digit write (s1_in):
  - If sw_in[3:0] ≤ 9, write it into nibble[cursor].
  - Otherwise leave the buffer unchanged and pulse err.
- Clear (s4_in): digits=0, dp_valid=0, dp_pos=0, cursor=0. Clear has priority over a write and over cursor moves in the same cycle. The S2 FSM is not affected.
- S2 FSM, states IDLE, PRESS, HELD:
  - IDLE: s2_in=1 → PRESS, counter=1.
  - PRESS, s2_in=1: counter increments. When counter reaches LONG_TICKS-1 → HELD, with confirm pulsed and op_code=sw_in[7:4] in the same cycle.
  - PRESS, s2_in=0: short press → IDLE. If dp_valid and dp_pos==cursor, clear dp_valid; otherwise dp_valid=1 and dp_pos=cursor. Only one decimal point can exist.
  - HELD: long_hold=1; s2_in=0 → IDLE with no short action.
- Counter width is 8 bits and saturates; it never wraps.
- A short-press dp action coinciding with s4_in: clear wins.

## Timing
- All outputs are registered and update on the clk_db edge after the input pulse (1-cycle latency).
- confirm rises exactly LONG_TICKS cycles after the first cycle s2_in is sampled high. It is high for exactly 1 cycle; long_hold rises in the same cycle.
- A short-press action happens 1 cycle after s2_in is sampled low. The shortest short press is 1 cycle high.
- rst asserted in any state (including mid-press) returns everything to reset values on the next edge. If S2 is still high after rst deasserts, it is treated as a new press from IDLE.
- Input pulses are assumed 1 cycle wide. A multi-cycle pulse acts once per high cycle.

## Configuration
- AUTO_ADVANCE_EN:
  - Defined: an accepted digit write also decrements cursor (moves right, wrap 0→7) in the same cycle. A simultaneous s0_in/s3_in is ignored that cycle.
  - Undefined: writes never move the cursor.
  - A rejected write (err) never moves the cursor in either build.

## Structure
- Shared package calc_pkg holds:
  - NUM_DIGITS=8 and the default LONG_TICKS;
  - the S2 state enum {IDLE, PRESS, HELD};
  - the BCD_MAX=9 constant.
- One sub-module, press_timer, holds the S2 FSM, the counter, confirm, long_hold and a short_press pulse. key_ctrl holds the buffer, cursor and dp logic.

## Test plan
- Reset, then 3× s0_in → cursor=3; then 4× s3_in → cursor=7 (wraps through 0).
- cursor=2, sw_in[3:0]=5, s1_in → digits=0x0000_0500, err=0. Then sw_in[3:0]=0xC, s1_in → digits unchanged, err pulses once.
- S2 high for 10 cycles at cursor=4 → dp_valid=1, dp_pos=4, no confirm. Repeat at cursor=4 → dp_valid=0.
- sw_in[7:4]=0xA, S2 held 150 cycles (LONG_TICKS=100) → confirm high exactly on cycle 100, op_code=0xA, long_hold high until release, dp unchanged.
- s1_in and s4_in in the same cycle → digits=0, cursor=0. rst asserted at cycle 50 of an S2 press → no confirm is generated.
- With AUTO_ADVANCE_EN: cursor=0, write 7 → digits nibble0=7, cursor=7.
